rr_sel_arbiter: RTL and testbench
=================================

Name: rr_sel_arbiter

Overview:
Round-robin arbiter that sits directly upstream of the 2-to-4 select decoder. It takes four channel request lines and produces the registered 2-bit select code the decoder expands into one-hot enables. Grants rotate fairly, are held stable while in use, and are revoked on release, request drop, or hold-time expiry.

Parameters:
HOLD_MAX, 4, maximum number of consecutive cycles one grant may stay valid (legal range 1..8)
CW, 3, width of the internal hold counter; must satisfy 2**CW >= HOLD_MAX

Ports:
clk  input  1  system clock; all state changes on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
req  input  4  request per channel; bit i = channel i
done  input  1  current grantee releases the grant (single-cycle or level)
sel  output  2  granted channel index; drives decoder select s[1:0]
sel_valid  output  1  sel is a live grant; decoder outputs meaningful only when high
timeout  output  1  one-cycle pulse when a grant is revoked by HOLD_MAX expiry
busy  output  1  high in GRANT state (equals sel_valid)

Behaviour:
- One clock; reset is synchronous and active-low: clk / rst_n.
- Reset (rst_n=0 at edge): state=IDLE, sel=2'b00, sel_valid=0, timeout=0, busy=0, ptr=0, cnt=0. Reset mid-grant drops the grant at that edge; no timeout pulse.
- All outputs registered; no combinational path from req/done to any output.
- ptr: 2-bit round-robin start index; search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
- States: IDLE, GRANT.
- IDLE: sel_valid=0, sel keeps last value. If req!=0 at edge: sel <= first set bit in search order, cnt <= 0, go GRANT. Else stay.
- Latency: req sampled high at edge n -> sel_valid=1 after edge n (visible cycle n+1).
- GRANT: sel_valid=1, sel stable (must not change). Each edge evaluates, in priority order:
  1. done=1 -> release: go IDLE, ptr <= sel+1.
  2. req[sel]=0 -> request dropped: go IDLE, ptr <= sel+1.
  3. cnt==HOLD_MAX-1 -> expiry: go IDLE, ptr <= sel+1, timeout=1 for the following cycle only.
  4. otherwise cnt <= cnt+1, stay.
- Grant duration is 1..HOLD_MAX cycles; HOLD_MAX=1 gives exactly one cycle per grant, with timeout pulsing unless done is high or req[sel] is low.
- done takes priority over expiry at the same edge: no timeout pulse.
- Mandatory one-cycle IDLE bubble between consecutive grants (sel_valid low for at least 1 cycle).
- ptr wraps 3 -> 0; sel+1 computed modulo 4.
- done or changes to req for non-granted channels while in GRANT are ignored; done in IDLE is ignored.
- timeout is 0 in every cycle except the one immediately following an expiry edge.

Test Plan:
- Reset: hold rst_n=0 for 2 edges with req=4'b1111 -> sel=00, sel_valid=0, timeout=0; release -> next edge grants sel=00.
- Rotation: req=4'b1111, done pulsed on every grant cycle -> grant sequence sel=0,1,2,3,0 with one sel_valid-low cycle between grants.
- Fair skip/wrap: after channel 2 granted and released, req=4'b0101 -> next grant sel=00 (ptr=3 wraps, channel 3 idle).
- Timeout: HOLD_MAX=4, req=4'b0010 held, done=0 -> sel_valid high exactly 4 cycles, then timeout=1 for 1 cycle, then re-grant sel=01 after the bubble.
- Priority: done=1 on the same edge as cnt==HOLD_MAX-1 -> release, timeout stays 0; req[sel] dropped mid-grant -> sel_valid falls next edge, no timeout.
- Reset mid-grant: rst_n=0 during GRANT with cnt=2 -> next cycle sel_valid=0, sel=00, ptr=0, no timeout pulse.

Source files
------------

// File: rtl/rr_sel_arbiter.sv
// Purpose: four-channel round-robin arbiter producing the registered 2-bit select code for a 2-to-4 decoder.
// Latency: a request sampled at edge n is granted after edge n; all outputs are registered.
// Backpressure: a grant is held until done, request drop or HOLD_MAX expiry; an IDLE cycle always separates grants.
module rr_sel_arbiter #(
  parameter int HOLD_MAX = 4,  // legal range 1..8
  parameter int CW       = 3   // 2**CW must be >= HOLD_MAX
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] sel,
  output logic       sel_valid,
  output logic       timeout,
  output logic       busy
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Count value on which the grant has been live for HOLD_MAX cycles.
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

  state_t        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q, timeout_d;

  logic [1:0]    pick;
  logic          any_req;
  logic [1:0]    sel_next_ptr;

  // First requesting channel in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    logic [1:0] choice;
    logic       found;
    choice = p;
    found  = 1'b0;
    for (int k = 0; k < 4; k++) begin
      idx = p + 2'(k);
      if (!found && r[idx]) begin
        choice = idx;
        found  = 1'b1;
      end
    end
    return choice;
  endfunction

  // Search result and the rotated start point used whenever a grant ends.
  always_comb begin
    any_req      = |req;
    pick         = rr_pick(req, ptr_q);
    sel_next_ptr = sel_q + 2'd1;
  end

  // Next-state logic: grant selection in IDLE, release/drop/expiry checks in GRANT.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // done is meaningless without a grant, so only req is looked at here.
        if (any_req) begin
          sel_d   = pick;
          cnt_d   = '0;
          state_d = ST_GRANT;
        end
      end

      ST_GRANT: begin
        // sel is frozen for the whole grant; only the exit reason differs.
        if (done) begin
          state_d = ST_IDLE;
          ptr_d   = sel_next_ptr;
        end else if (!req[sel_q]) begin
          state_d = ST_IDLE;
          ptr_d   = sel_next_ptr;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          ptr_d     = sel_next_ptr;
          timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset; reset drops any live grant silently.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      sel_q     <= 2'b00;
      ptr_q     <= 2'b00;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Outputs come straight from flops so the decoder never sees a req/done glitch.
  always_comb begin
    sel       = sel_q;
    sel_valid = (state_q == ST_GRANT);
    busy      = (state_q == ST_GRANT);
    timeout   = timeout_q;
  end

endmodule

// File: tb/tb_rr_sel_arbiter.sv
// Purpose: directed self-checking bench for rr_sel_arbiter (HOLD_MAX=4).
// Latency: inputs applied 1 time unit after an edge, outputs checked 1 time unit after the next edge.
// Backpressure: not applicable; the bench drives req/done directly.
module tb_rr_sel_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic       sel_valid;
  logic       timeout;
  logic       busy;

  int n_checks;
  int n_pass;

  rr_sel_arbiter #(.HOLD_MAX(4), .CW(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .done      (done),
    .sel       (sel),
    .sel_valid (sel_valid),
    .timeout   (timeout),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] exp_sel;
    logic       exp_vld;
    logic       exp_to;
    string      name;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic r, input logic [3:0] q, input logic d,
                              input logic [1:0] s, input logic v, input logic t,
                              input string nm);
    vec_t x;
    x.rst_n = r; x.req = q; x.done = d;
    x.exp_sel = s; x.exp_vld = v; x.exp_to = t; x.name = nm;
    return x;
  endfunction

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outputs(input string nm, input logic [1:0] s, input logic v, input logic t);
    check({nm, ".sel"},       {2'b00, sel}, {2'b00, s});
    check({nm, ".sel_valid"}, {3'b000, sel_valid}, {3'b000, v});
    check({nm, ".timeout"},   {3'b000, timeout}, {3'b000, t});
    check({nm, ".busy"},      {3'b000, busy}, {3'b000, v});
  endtask

  initial begin
    int hi_cycles;
    int waited;
    bit got_to;

    n_checks = 0;
    n_pass   = 0;
    rst_n = 1'b0;
    req   = 4'b1111;
    done  = 1'b0;

    // Each row: inputs held across the next edge, outputs expected after it.
    // Reset with all requests pending.
    vecs.push_back(mk(0, 4'b1111, 0, 2'd0, 0, 0, "rst0"));
    vecs.push_back(mk(0, 4'b1111, 0, 2'd0, 0, 0, "rst1"));
    // Rotation 0,1,2,3,0 with a bubble between grants.
    vecs.push_back(mk(1, 4'b1111, 0, 2'd0, 1, 0, "rot_g0"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd0, 0, 0, "rot_r0"));
    vecs.push_back(mk(1, 4'b1111, 0, 2'd1, 1, 0, "rot_g1"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd1, 0, 0, "rot_r1"));
    vecs.push_back(mk(1, 4'b1111, 0, 2'd2, 1, 0, "rot_g2"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd2, 0, 0, "rot_r2"));
    vecs.push_back(mk(1, 4'b1111, 0, 2'd3, 1, 0, "rot_g3"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd3, 0, 0, "rot_r3"));
    vecs.push_back(mk(1, 4'b1111, 0, 2'd0, 1, 0, "rot_g0b"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd0, 0, 0, "rot_r0b"));
    // Channel 2 granted/released, ptr=3; channel 3 idle so search wraps to 0.
    vecs.push_back(mk(1, 4'b0100, 0, 2'd2, 1, 0, "wrap_g2"));
    vecs.push_back(mk(1, 4'b0100, 1, 2'd2, 0, 0, "wrap_r2"));
    vecs.push_back(mk(1, 4'b0101, 0, 2'd0, 1, 0, "wrap_g0"));
    vecs.push_back(mk(1, 4'b0101, 1, 2'd0, 0, 0, "wrap_r0"));
    // Hold-time expiry: four grant cycles, then one timeout cycle.
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "to_c0"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "to_c1"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "to_c2"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "to_c3"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 0, 1, "to_exp"));
    // Re-grant after bubble, then done on the expiry edge suppresses timeout.
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "pr_c0"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "pr_c1"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "pr_c2"));
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "pr_c3"));
    vecs.push_back(mk(1, 4'b0010, 1, 2'd1, 0, 0, "pr_done"));
    // Request drop mid-grant, then done while idle is ignored.
    vecs.push_back(mk(1, 4'b0010, 0, 2'd1, 1, 0, "drop_g"));
    vecs.push_back(mk(1, 4'b0000, 0, 2'd1, 0, 0, "drop"));
    vecs.push_back(mk(1, 4'b0000, 0, 2'd1, 0, 0, "idle"));
    vecs.push_back(mk(1, 4'b0000, 1, 2'd1, 0, 0, "idle_done"));
    // ptr=2: channel 3 granted; other channels' req changes do not disturb it.
    vecs.push_back(mk(1, 4'b1000, 0, 2'd3, 1, 0, "mr_g3"));
    vecs.push_back(mk(1, 4'b1001, 0, 2'd3, 1, 0, "mr_c1"));
    vecs.push_back(mk(1, 4'b1000, 0, 2'd3, 1, 0, "mr_c2"));
    // Reset while cnt=2: grant drops, no timeout, ptr returns to 0.
    vecs.push_back(mk(0, 4'b1000, 0, 2'd0, 0, 0, "mr_rst"));
    vecs.push_back(mk(1, 4'b1111, 0, 2'd0, 1, 0, "mr_ptr0"));
    vecs.push_back(mk(1, 4'b1111, 1, 2'd0, 0, 0, "mr_rel"));

    #1;
    foreach (vecs[i]) begin
      rst_n = vecs[i].rst_n;
      req   = vecs[i].req;
      done  = vecs[i].done;
      step();
      check_outputs(vecs[i].name, vecs[i].exp_sel, vecs[i].exp_vld, vecs[i].exp_to);
    end

    // Hand-written: channel 0 held continuously (ptr=1 now); count live cycles until timeout.
    req  = 4'b0001;
    done = 1'b0;
    hi_cycles = 0;
    got_to    = 1'b0;
    waited    = 0;
    while (!got_to && waited < 12) begin
      step();
      waited++;
      if (sel_valid) hi_cycles++;
      if (timeout) got_to = 1'b1;
    end
    check("hold.timeout_seen", {3'b000, got_to}, 4'd1);
    check("hold.live_cycles", 4'(hi_cycles), 4'd4);
    check("hold.bubble_vld", {3'b000, sel_valid}, 4'd0);
    step();
    check("hold.pulse_width", {3'b000, timeout}, 4'd0);
    check("hold.regrant_vld", {3'b000, sel_valid}, 4'd1);
    check("hold.regrant_sel", {2'b00, sel}, 4'd0);

    // Hand-written: drop the request after one cycle; no timeout in the two cycles after.
    req = 4'b0000;
    step();
    check("drop2.vld", {3'b000, sel_valid}, 4'd0);
    check("drop2.to", {3'b000, timeout}, 4'd0);
    step();
    check("drop2.to_late", {3'b000, timeout}, 4'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
